// File: rtl/ads_knob_bus_arbiter.sv
// Round-robin arbiter sharing the ADS7830 I2C read port between the periodic
// channel-scan reader (m0) and an on-demand requester (m1). Each grant ends on
// slave data or a forced timeout.
module ads_knob_bus_arbiter #(
    parameter int                 ADDR_W         = 3,
    parameter int                 DATA_W         = 8,
    parameter int                 TIMEOUT_CYCLES = 250000,
    parameter logic [DATA_W-1:0]  TIMEOUT_DATA   = DATA_W'(8'hFF)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              m0_read_i,
    input  logic [ADDR_W-1:0] m0_address_i,
    output logic [DATA_W-1:0] m0_readdata_o,
    output logic              m0_readdatavalid_o,
    input  logic              m1_read_i,
    input  logic [ADDR_W-1:0] m1_address_i,
    output logic [DATA_W-1:0] m1_readdata_o,
    output logic              m1_readdatavalid_o,
    output logic              s_read_o,
    output logic [ADDR_W-1:0] s_address_o,
    input  logic [DATA_W-1:0] s_readdata_i,
    input  logic              s_readdatavalid_i,
    output logic [1:0]        grant_o,
    output logic              timeout_o,
    output logic              dbg_state_o
);

    // Handshake: a master holds mN_read_i high until its one-cycle mN_readdatavalid_o;
    // the slave side sees s_read_o held for the whole BUSY period and answers with
    // a one-cycle s_readdatavalid_i, which is forwarded to the owner in the same cycle.

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_owner;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_last_grant;
    logic [CNT_W-1:0]    r_count;

    logic                w_req_any;
    logic                w_win;
    logic                w_done;
    logic                w_timeout;
    logic                w_finish;
    logic [DATA_W-1:0]   w_data;

    always_comb begin
        w_next_state = r_state;
        w_req_any    = m0_read_i | m1_read_i;
        w_win        = 1'b0;
        if (m0_read_i && m1_read_i) begin
            w_win = ~r_last_grant;
        end else if (m1_read_i) begin
            w_win = 1'b1;
        end
        // Real data beats a timeout landing in the same cycle.
        w_done    = (r_state == ST_BUSY) && s_readdatavalid_i;
        w_timeout = (r_state == ST_BUSY) && !s_readdatavalid_i && (r_count == CNT_LAST);
        w_finish  = w_done | w_timeout;
        w_data    = w_done ? s_readdata_i : TIMEOUT_DATA;
        case (r_state)
            ST_IDLE: if (w_req_any) w_next_state = ST_BUSY;
            ST_BUSY: if (w_finish)  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_addr       <= '0;
            r_last_grant <= 1'b1;
            r_count      <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE) begin
                if (w_req_any) begin
                    r_owner      <= w_win;
                    r_addr       <= w_win ? m1_address_i : m0_address_i;
                    r_last_grant <= w_win;
                    r_count      <= '0;
                end
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        m0_readdatavalid_o = w_finish && !r_owner;
        m1_readdatavalid_o = w_finish && r_owner;
        m0_readdata_o      = m0_readdatavalid_o ? w_data : '0;
        m1_readdata_o      = m1_readdatavalid_o ? w_data : '0;
        s_read_o           = (r_state == ST_BUSY);
        s_address_o        = (r_state == ST_BUSY) ? r_addr : '0;
        grant_o            = (r_state == ST_BUSY) ? {r_owner, ~r_owner} : 2'b00;
        timeout_o          = w_timeout;
        dbg_state_o        = r_state;
    end

endmodule
